mrfm_chan_serializer: RTL
=========================

Name: mrfm_chan_serializer

Overview:
- Parametrised successor to the fixed four-channel i/q/ip/qp collection path in the MRFM receive chain.
- On each processing strobe, atomically snapshots up to NCH parallel channel samples.
- Serialises the snapshot into an internal show-ahead FIFO, one word per cycle.
- Presents the FIFO through a valid/ready interface to the RX buffer writer. Adds runtime channel count, frame markers, atomic frame drop and sticky overrun reporting.

Parameters:
- NCH, 8, maximum number of channels; must be ≥1.
- WIDTH, 16, bits per sample.
- DEPTH, 16, FIFO depth in words; must be a power of 2 and ≥NCH.

Ports:
- clock  in  1  sole clock (clk64 domain).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  allows new frames to be accepted.
- numchan  in  4  channels per frame, runtime value.
- strobe_in  in  1  single-cycle sample strobe from the processing chain.
- ch_data  in  NCH*WIDTH  channel samples; channel k occupies bits [k*WIDTH +: WIDTH].
- out_ready  in  1  consumer accepts out_data this cycle.
- clear_status  in  1  clears overrun.
- out_data  out  WIDTH  head-of-FIFO word.
- out_first  out  1  head word is channel 0 of a frame.
- out_valid  out  1  FIFO non-empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy in words.
- overrun  out  1  sticky; at least one frame was dropped.
- busy  out  1  serialiser is not IDLE.

Behaviour:
- Reset: all outputs go to 0 asynchronously. FIFO is emptied, state is IDLE, latched channel count is 1.
- Effective channel count: nc = numchan clamped to the range 1..NCH (0 becomes 1; values above NCH become NCH). nc is latched only when a frame is accepted, so changing numchan mid-frame has no effect on that frame.
- State machine:
  - IDLE → SER when strobe_in=1, enable=1 and (DEPTH − level) ≥ nc. On that edge the block captures ch_data into a holding register, latches nc and clears the index counter.
  - SER: each cycle, writes holding[idx] into the FIFO along with a first flag equal to (idx==0), then increments idx. After writing idx = nc−1 it returns to IDLE. A frame of nc channels therefore spends exactly nc cycles in SER.
  - A strobe that is accepted at cycle t produces channel-0 write at t+1 and out_valid high at t+2 if the FIFO was empty.
  - The space check is conservative. It uses level at the strobe cycle, and a read in the same cycle is not credited.
- Drop rules:
  - strobe_in with enable=1 while in SER drops the whole frame and sets overrun. The current frame continues unaffected.
  - strobe_in with enable=1 in IDLE with insufficient space drops the whole frame and sets overrun. No partial frame is ever written.
  - strobe_in with enable=0 is ignored silently; overrun is not set.
- Deasserting enable mid-frame: the current frame completes; no new frames are accepted.
- overrun: set has priority over clear_status in the same cycle. Otherwise clear_status=1 clears it.
- FIFO:
  - Show-ahead. out_data and out_first are valid whenever out_valid=1.
  - A pop occurs on out_valid & out_ready; out_ready with an empty FIFO is ignored.
  - Simultaneous write and pop leaves level unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - level = DEPTH is reachable; a full FIFO is never written because of the frame space check.
- busy = (state == SER).

Test Plan:
- NCH=8, numchan=4, ch_data channels 0..3 = 0x1111, 0x2222, 0x3333, 0x4444, single strobe, out_ready=1 → four words in order. out_first is 1 only on 0x1111. out_valid first goes high 2 cycles after the strobe; busy is high for 4 cycles.
- numchan=0, then numchan=12 → 1-word frames and 8-word frames respectively. Change numchan from 2 to 6 in the cycle after a strobe → that frame is still 2 words.
- DEPTH=16, numchan=8, out_ready=0, three strobes spaced 10 cycles apart → level=16 after the second frame. The third frame is dropped, overrun=1, and level stays 16. Then apply clear_status=1 with no strobe → overrun=0.
- numchan=4, a second strobe 2 cycles after the first → the second frame is dropped and overrun=1. Output is exactly one frame of 4 words with intact order.
- Assert reset_n=0 mid-SER with level=5 → out_valid, level, busy and overrun are all 0 immediately. After release, the next strobe yields a clean frame with out_first on its first word.
- Continuous strobes every 8 cycles with numchan=4 and out_ready toggling 1,0,1,0 for 1000 frames → no overrun; the scoreboard matches all 4000 words, including across pointer wrap-around.

Source files
------------

// File: rtl/mrfm_chan_serializer.sv
// Snapshots up to NCH channel samples per strobe and serialises them, one word per
// cycle, into a show-ahead FIFO presented to the RX buffer writer over valid/ready.
module mrfm_chan_serializer #(
  parameter int NCH   = 8,
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [3:0]               numchan,
  input  logic                     strobe_in,
  input  logic [NCH*WIDTH-1:0]     ch_data,
  input  logic                     out_ready,
  input  logic                     clear_status,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_first,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (AW > 0) ? AW : 1;

  typedef enum logic {S_IDLE, S_SER} state_t;

  typedef struct packed {
    logic             first;
    logic [WIDTH-1:0] data;
  } word_t;

  state_t               state;
  logic [3:0]           nc_q;
  logic [3:0]           idx;
  logic [3:0]           nc_eff;
  logic [NCH*WIDTH-1:0] holding;
  logic [WIDTH-1:0]     wr_data;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  word_t                mem [DEPTH];
  word_t                head;
  logic                 space_ok;
  logic                 accept;
  logic                 drop;
  logic                 wr_en;
  logic                 rd_en;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    nc_eff = numchan;
    if (numchan == 4'd0)
      nc_eff = 4'd1;
    else if (int'(numchan) > NCH)
      nc_eff = 4'(NCH);
  end

  // Space is judged on the current level only; a pop in the same cycle is not credited.
  assign space_ok = (DEPTH - int'(level)) >= int'(nc_eff);
  assign accept   = strobe_in && enable && (state == S_IDLE) && space_ok;
  assign drop     = strobe_in && enable && !accept;
  assign wr_en    = (state == S_SER);
  assign out_valid = (level != '0);
  assign rd_en    = out_valid && out_ready;
  assign busy     = (state == S_SER);

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < NCH; k++)
      if (int'(idx) == k) wr_data = holding[k*WIDTH +: WIDTH];
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      nc_q    <= 4'd1;
      idx     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_SER;
            nc_q  <= nc_eff;
            idx   <= '0;
          end
        end
        S_SER: begin
          idx <= idx + 4'd1;
          if (idx == nc_q - 4'd1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (drop)
        overrun <= 1'b1;
      else if (clear_status)
        overrun <= 1'b0;

      if (wr_en)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (rd_en)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

      case ({wr_en, rd_en})
        2'b10:   level <= level + ($clog2(DEPTH)+1)'(1);
        2'b01:   level <= level - ($clog2(DEPTH)+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by level and outputs are gated by out_valid.
  always_ff @(posedge clock) begin
    if (accept)
      holding <= ch_data;
    if (wr_en)
      mem[wr_ptr] <= word_t'{first: (idx == 4'd0), data: wr_data};
  end

  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head.data : '0;
  assign out_first = out_valid && head.first;

endmodule
